// File: rtl/irq_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_arbiter_if : interrupt lines, mask port and CPU intr/ack/eret bundle |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface irq_arbiter_if #(
  parameter int N_SRC = 4,
  parameter int PC_W  = 26
);
  logic [N_SRC-1:0] irq;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             ack;
  logic             eret;
  logic [PC_W-1:0]  pc;
  logic             intr;
  logic             busy;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pending;
  logic [31:0]      cause;
  logic [31:0]      epc;

  modport master (
    output irq, mask_we, mask_wdata, ack, eret, pc,
    input  intr, busy, mask, pending, cause, epc
  );

  modport slave (
    input  irq, mask_we, mask_wdata, ack, eret, pc,
    output intr, busy, mask, pending, cause, epc
  );
endinterface
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_arbiter : edge-detect, pend, mask and fixed-priority sequencer for  |
// |               the CPU intr/ack/eret handshake. Revision 1.0              |
// +--------------------------------------------------------------------------+
module irq_arbiter #(
  parameter int N_SRC = 4,
  parameter int PC_W  = 26
) (
  input  wire logic     clk,
  input  wire logic     rst,
  irq_arbiter_if.slave  bus
);
  localparam int IDX_W = 5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [IDX_W-1:0] winner_q,  winner_d;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q,    mask_d;
  logic [31:0]      cause_q,   cause_d;
  logic [31:0]      epc_q,     epc_d;

  logic [N_SRC-1:0] irq_edge;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [IDX_W-1:0] win_idx;

  assign irq_edge = bus.irq & ~irq_q;
  assign eligible = pending_q & mask_q;

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    clr      = '0;
    win_idx  = '0;
    // Ascending scan: the last hit is the highest index, which has priority.
    for (int i = 0; i < N_SRC; i++) begin
      if (eligible[i]) win_idx = IDX_W'(i);
    end
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          winner_d = win_idx;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.ack) begin
          epc_d   = 32'(bus.pc);
          cause_d = 32'(winner_q) + 32'd1;
          state_d = ST_SERVICE;
          for (int i = 0; i < N_SRC; i++) begin
            clr[i] = (winner_q == IDX_W'(i));
          end
        end
      end
      ST_SERVICE: begin
        if (bus.eret) begin
          cause_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A fresh edge in the ack cycle re-pends the winner: set beats clear.
  assign pending_d = (pending_q & ~clr) | irq_edge;
  assign mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      winner_q  <= '0;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      cause_q   <= '0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      irq_q     <= bus.irq;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
    end
  end

  assign bus.intr    = (state_q == ST_REQ);
  assign bus.busy    = (state_q == ST_SERVICE);
  assign bus.mask    = mask_q;
  assign bus.pending = pending_q;
  assign bus.cause   = cause_q;
  assign bus.epc     = epc_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_irq_arbiter : directed stimulus with a queue-based service scoreboard |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_irq_arbiter;
  localparam int N_SRC = 4;
  localparam int PC_W  = 26;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] epc;
  } svc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  svc_t exp_q[$];
  logic busy_prev = 1'b0;

  irq_arbiter_if #(.N_SRC(N_SRC), .PC_W(PC_W)) bus ();

  irq_arbiter #(.N_SRC(N_SRC), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every entry into service must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.busy && !busy_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_service", 32'd1, 32'd0);
      end else begin
        svc_t e;
        e = exp_q.pop_front();
        check("sb_cause", bus.cause, e.cause);
        check("sb_epc",   bus.epc,   e.epc);
      end
    end
    busy_prev <= bus.busy;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int idx);
    bus.irq[idx] = 1'b1;
    step();
    bus.irq[idx] = 1'b0;
  endtask

  task automatic wait_intr(input int max_cycles);
    int n = 0;
    while (!bus.intr && n < max_cycles) begin
      step();
      n++;
    end
    check("wait_intr", {31'd0, bus.intr}, 32'd1);
  endtask

  task automatic do_ack(input logic [PC_W-1:0] pc_v, input logic [31:0] exp_cause);
    svc_t e;
    e.cause = exp_cause;
    e.epc   = {{(32-PC_W){1'b0}}, pc_v};
    exp_q.push_back(e);
    bus.pc  = pc_v;
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("ack_intr_low", {31'd0, bus.intr}, 32'd0);
    check("ack_busy",     {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic do_eret(input logic [PC_W-1:0] pc_v);
    bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;
    check("eret_cause", bus.cause, 32'd0);
    check("eret_busy",  {31'd0, bus.busy}, 32'd0);
    check("eret_epc_hold", bus.epc, {{(32-PC_W){1'b0}}, pc_v});
  endtask

  initial begin
    int stuck;
    bus.irq = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.ack = 1'b0; bus.eret = 1'b0; bus.pc = '0;

    // Reset state
    rst = 1'b1;
    step(2);
    check("rst_intr",    {31'd0, bus.intr}, 32'd0);
    check("rst_busy",    {31'd0, bus.busy}, 32'd0);
    check("rst_cause",   bus.cause, 32'd0);
    check("rst_epc",     bus.epc, 32'd0);
    check("rst_pending", {28'd0, bus.pending}, 32'd0);
    check("rst_mask",    {28'd0, bus.mask}, 32'hF);
    rst = 1'b0;
    step();

    // Single source with 2-cycle latency and a long REQ hold
    bus.irq[0] = 1'b1;
    step();
    bus.irq[0] = 1'b0;
    check("single_pending", {28'd0, bus.pending}, 32'h1);
    check("single_intr_lat1", {31'd0, bus.intr}, 32'd0);
    step();
    check("single_intr_lat2", {31'd0, bus.intr}, 32'd1);
    step(2);
    check("single_intr_hold", {31'd0, bus.intr}, 32'd1);
    do_ack(26'h0000123, 32'd1);
    check("single_pending_clr", {28'd0, bus.pending}, 32'h0);
    step(2);
    do_eret(26'h0000123);

    // Priority: watchdog beats user input, then user input after one idle cycle
    bus.irq = 4'b0011;
    step();
    bus.irq = 4'b0000;
    wait_intr(4);
    do_ack(26'h0000200, 32'd2);
    check("prio_pending_left", {28'd0, bus.pending}, 32'h1);
    step();
    do_eret(26'h0000200);
    check("prio_idle_gap", {31'd0, bus.intr}, 32'd0);
    step();
    check("prio_reassert", {31'd0, bus.intr}, 32'd1);
    do_ack(26'h0000300, 32'd1);
    do_eret(26'h0000300);

    // Mask holds off a pending source until re-enabled
    bus.mask_wdata = 4'b1110; bus.mask_we = 1'b1;
    step();
    bus.mask_we = 1'b0;
    check("mask_value", {28'd0, bus.mask}, 32'hE);
    pulse(0);
    check("mask_pending", {28'd0, bus.pending}, 32'h1);
    stuck = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.intr) stuck++;
    end
    check("mask_intr_blocked", stuck, 32'd0);
    bus.mask_wdata = 4'b1111; bus.mask_we = 1'b1;
    step();
    bus.mask_we = 1'b0;
    check("unmask_intr_lat1", {31'd0, bus.intr}, 32'd0);
    step();
    check("unmask_intr_lat2", {31'd0, bus.intr}, 32'd1);
    do_ack(26'h0000400, 32'd1);
    do_eret(26'h0000400);

    // Coalesce three edges during service, then set-wins in the ack cycle
    pulse(2);
    wait_intr(4);
    do_ack(26'h0000500, 32'd3);
    for (int i = 0; i < 3; i++) begin
      pulse(1);
      step();
    end
    check("coalesce_pending", {28'd0, bus.pending}, 32'h2);
    do_eret(26'h0000500);
    step();
    check("coalesce_intr", {31'd0, bus.intr}, 32'd1);
    bus.irq[1] = 1'b1;
    do_ack(26'h0000600, 32'd2);
    bus.irq[1] = 1'b0;
    check("setwins_pending", {28'd0, bus.pending}, 32'h2);
    do_eret(26'h0000600);
    wait_intr(4);
    do_ack(26'h0000700, 32'd2);
    check("setwins_cleared", {28'd0, bus.pending}, 32'h0);
    do_eret(26'h0000700);

    // Held-high line yields a single event
    bus.irq[3] = 1'b1;
    wait_intr(4);
    do_ack(26'h0000800, 32'd4);
    do_eret(26'h0000800);
    stuck = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.intr) stuck++;
    end
    check("held_single_event", stuck, 32'd0);
    check("held_pending", {28'd0, bus.pending}, 32'h0);
    bus.irq[3] = 1'b0;
    step();

    // Stray handshakes: ack in IDLE, eret in REQ, ack+eret together in REQ
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("ack_idle_ignored", {31'd0, bus.busy}, 32'd0);
    pulse(0);
    wait_intr(4);
    bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;
    check("eret_req_ignored", {31'd0, bus.intr}, 32'd1);
    bus.eret = 1'b1;
    do_ack(26'h0000900, 32'd1);
    bus.eret = 1'b0;
    step();
    check("ack_eret_busy", {31'd0, bus.busy}, 32'd1);

    // Reset in SERVICE with another source pending
    pulse(2);
    check("midrst_pending", {28'd0, bus.pending}, 32'h4);
    rst = 1'b1;
    step();
    check("midrst_intr",    {31'd0, bus.intr}, 32'd0);
    check("midrst_busy",    {31'd0, bus.busy}, 32'd0);
    check("midrst_pending", {28'd0, bus.pending}, 32'h0);
    check("midrst_cause",   bus.cause, 32'd0);
    rst = 1'b0;
    step(3);
    check("midrst_stay_idle", {31'd0, bus.intr}, 32'd0);

    check("sb_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/irq_arbiter.md
# irq_arbiter

Multi-source interrupt arbiter and sequencer sitting between the peripheral interrupt lines (user input, watchdog, timers) and the CPU control unit. Edge-detects each source, holds it pending, applies a software mask, selects one winner by fixed priority, and runs the intr/ack/eret handshake with the control unit. Captures the return PC and a cause code at acknowledge, and clears the cause on return; nesting is not supported.

## Interface
- N_SRC, 4, number of interrupt sources (1..31); source i reports cause i+1
- PC_W, 26, width of the PC captured into epc

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- irq  in  N_SRC  source request lines, level, synchronous to clk; bit 0 = user input, bit 1 = watchdog
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  N_SRC  new mask value (1 = source enabled)
- ack  in  1  control unit accepts the interrupt (taken at the branch to the handler)
- eret  in  1  control unit returns from handler
- pc  in  PC_W  PC to save on acknowledge
- intr  out  1  interrupt request to control unit
- busy  out  1  handler in progress (state SERVICE)
- mask  out  N_SRC  current mask register
- pending  out  N_SRC  current pending bits
- cause  out  32  cause code of the interrupt being serviced, 0 when none
- epc  out  32  saved PC, zero-extended from PC_W

## Operation
- Edge detect: irq_q <= irq each cycle; edge[i] = irq[i] & ~irq_q[i]. pending[i] sets on edge[i].
- Mask: mask <= mask_wdata when mask_we. Masked sources still latch pending; they are merely not eligible.
- Eligible = pending & mask. Priority: highest index wins (watchdog beats user input).
- States:
  - IDLE: intr=0, busy=0. If eligible != 0: latch winner index, go REQ.
  - REQ: intr=1. Winner locked; later higher-priority edges or mask writes do not change it. On ack: epc <= zero-extended pc, cause <= winner+1, pending[winner] cleared, go SERVICE.
  - SERVICE: intr=0, busy=1. Pending keeps accumulating. On eret: cause <= 0, go IDLE. epc holds its value.
- Width: cause = {zeros, winner+1} in 32 bits; epc = {(32-PC_W) zeros, pc}.
- Boundary rules:
  - Edge on pending[winner] in the ack cycle: set wins, bit stays 1 (new event, serviced later).
  - ack in IDLE or SERVICE: ignored. eret in IDLE or REQ: ignored. ack and eret together in REQ: ack taken, eret ignored.
  - Repeated edge on an already pending source: coalesced, single service.
  - Held-high irq: one event only; a new event needs a low cycle first.
  - rst at any time, including mid-REQ/SERVICE: immediate return to IDLE, pending lost.

## Timing
- Reset values: state IDLE, intr=0, busy=0, pending=0, cause=0, epc=0, irq_q=0, mask=all ones. An irq held high across reset release counts as an edge on the first post-reset cycle.
- Latency: irq sampled high at edge k -> pending=1 after k -> intr=1 after k+1 (2 cycles).
- ack sampled at edge m -> after m: intr=0, busy=1, cause/epc valid, pending bit cleared.
- eret sampled at edge n -> after n: cause=0, busy=0. If eligible != 0, intr=1 after n+1 (one IDLE cycle between services).
- Mask write takes effect for eligibility in the following cycle.
- All outputs registered except intr and busy, which decode directly from the state register (glitch-free).

## Test plan
- Reset: assert rst 2 cycles with irq=0 -> intr=0, busy=0, cause=0, epc=0, pending=0, mask=4'b1111.
- Single source: pulse irq[0] at edge k, ack at k+4 with pc=26'h0000123 -> intr=1 from k+1..k+4, cause=1, epc=32'h00000123, pending=0; eret -> cause=0, busy=0.
- Priority: irq[0] and irq[1] rise in the same cycle -> cause=2 first; after eret, intr reasserts two cycles later and the next ack gives cause=1.
- Mask: mask_wdata=4'b1110 written, pulse irq[0] -> pending[0]=1, intr stays 0 for 20 cycles; write mask=4'b1111 -> intr=1 two cycles later.
- Coalesce and set-wins: irq[1] pulsed 3 times during SERVICE -> exactly one further service with cause=2; an edge on the winner in the ack cycle leaves pending[winner]=1.
- Reset mid-operation: rst asserted in SERVICE with pending=4'b0100 -> next cycle IDLE, pending=0, cause=0, intr=0.
